mac_stream_cluster: RTL and testbench
=====================================

// Module: mac_stream_cluster
// PURPOSE
//   Parametrised successor to mac_cluster: NUM_LANES independent MAC lanes computing
//   per-lane dot products of cfg_len operand beats, with valid/ready handshakes on config,
//   operand and result channels. Sits between an operand streamer and result writeback,
//   replacing free-running accumulation with counted transactions and a 2-stage pipe.
// PARAMETERS
//   NUM_LANES      4   number of independent MAC lanes
//   MAC_MIN_WIDTH  8   operand width per lane
//   MAC_ACC_WIDTH  32  accumulator/result width per lane (>= 2*MAC_MIN_WIDTH)
//   LEN_WIDTH      8   width of beat-count field cfg_len
// PORTS
//   clk         in   1                        clock, all logic on posedge
//   rst_n       in   1                        synchronous reset, active-low
//   cfg_valid   in   1                        config offer
//   cfg_ready   out  1                        config accept (IDLE only)
//   cfg_signed  in   1                        1: two's-complement operands, 0: unsigned
//   cfg_len     in   LEN_WIDTH                beats to accumulate per transaction
//   cfg_init    in   NUM_LANES*MAC_ACC_WIDTH  per-lane initial accumulator value
//   in_valid    in   1                        operand beat offer
//   in_ready    out  1                        operand beat accept
//   in_a, in_b  in   NUM_LANES*MAC_MIN_WIDTH  lane i = [i*MAC_MIN_WIDTH +: MAC_MIN_WIDTH]
//   out_valid   out  1                        result offer
//   out_ready   in   1                        result accept
//   out_data    out  NUM_LANES*MAC_ACC_WIDTH  lane i = [i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH]
//   sat_flag    out  NUM_LANES                sticky per-lane saturation (0 without macro)
// BEHAVIOUR
//   - Reset (rst_n low at posedge): state IDLE, beat counter 0, product stage invalid,
//     out_valid 0, out_data 0, sat_flag 0; cfg_ready 1 and in_ready 0 from next cycle.
//     Reset mid-transaction discards all partial state; no result emitted.
//   - FSM IDLE -> RUN -> DRAIN -> HOLD -> IDLE.
//     IDLE: cfg_ready=1; on cfg_valid latch signed/len/init into accumulators, clear
//       counter and sat_flag; go RUN (len>0) or HOLD (len==0: out_data=cfg_init).
//     RUN: in_ready=1; beat accepted when in_valid&in_ready; counter++; after beat
//       number len accepted, in_ready drops same edge, go DRAIN.
//     DRAIN: one cycle, final product added; go HOLD.
//     HOLD: out_valid=1, out_data stable until out_valid&out_ready; then IDLE.
//   - Pipeline: stage 1 registers per-lane product (2*MAC_MIN_WIDTH, sign- or
//     zero-extended per cfg_signed); stage 2 adds into MAC_ACC_WIDTH accumulator.
//   - Latency: out_valid rises 2 cycles after the edge accepting the final beat;
//     len==0: out_valid the cycle after config accept.
//   - in_valid gaps stall counting only; no bubble penalty beyond gap length.
//   - cfg_valid ignored outside IDLE; one idle bubble between result accept and next cfg.
//   - Arithmetic default: modulo 2^MAC_ACC_WIDTH wrap, no overflow indication.
// CONFIGURATION
//   MAC_SAT_EN defined: each stage-2 add saturates per lane (signed to
//     [-2^(ACC-1), 2^(ACC-1)-1], unsigned to [0, 2^ACC-1]); sat_flag[i] set on any
//     clamp in lane i, sticky until next config accept or reset.
//   MAC_SAT_EN undefined: wrap-around add, sat_flag tied 0, no saturation logic.
// TESTING (NUM_LANES=4, MAC_MIN_WIDTH=8, MAC_ACC_WIDTH=32)
//   1 unsigned, len=1, init=0, all lanes a=b=255 -> out_data lanes 65025, out_valid 2 cyc after beat
//   2 signed, len=3, init=10, a=-128,b=127 x3 -> each lane 0xFFFF418A (-48758)
//   3 len=4, in_valid 1-0-1-0-1-1, out_ready low 5 cyc -> out_data stable, in_ready=0, cfg_ready=0
//   4 len=0, init={4,3,2,1} -> out_valid cycle after cfg accept, out_data lanes 1,2,3,4
//   5 unsigned, init=0xFFFFFFF0, a=b=16, len=1 -> 0x000000F0 & sat_flag=0; MAC_SAT_EN: 0xFFFFFFFF & sat_flag=4'hF
//   6 rst_n low after 2 of 4 beats -> IDLE, out_valid=0, out_data=0; next transaction (test 1) correct

Source files
------------

// File: rtl/mac_stream_cluster.sv
// mac_stream_cluster: NUM_LANES independent MAC lanes, counted dot-product transactions (optional saturation: define MAC_SAT_EN).
// Latency: result valid in the second cycle after the edge accepting the last beat; cfg_len==0 -> the cycle after config accept.
// Backpressure: in_valid gaps stall beat counting only; result held stable in HOLD until out_ready; cfg accepted in IDLE only.
module mac_stream_cluster #(
    parameter int NUM_LANES     = 4,
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 32,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic                               cfg_signed,
    input  logic [LEN_WIDTH-1:0]               cfg_len,
    input  logic [NUM_LANES*MAC_ACC_WIDTH-1:0] cfg_init,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] in_a,
    input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] in_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_LANES*MAC_ACC_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]               sat_flag
);

    localparam int W  = MAC_MIN_WIDTH;
    localparam int PW = 2 * MAC_MIN_WIDTH;
    localparam int AW = MAC_ACC_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                          r_state;
    logic [LEN_WIDTH-1:0]            r_len;
    logic [LEN_WIDTH-1:0]            r_cnt;
    logic                            r_signed;
    logic                            r_cfg_ready;
    logic                            r_in_ready;
    logic                            r_out_valid;
    logic                            r_prod_vld;
    logic [NUM_LANES-1:0][PW-1:0]    r_prod;
    logic [NUM_LANES-1:0][AW-1:0]    r_acc;

    logic [NUM_LANES-1:0][PW-1:0]    w_prod;
    logic [NUM_LANES-1:0][AW-1:0]    w_acc_nxt;
    logic [LEN_WIDTH-1:0]            w_cnt_nxt;
    logic                            w_cfg_fire;
    logic                            w_beat_fire;

    assign w_cfg_fire  = cfg_valid & r_cfg_ready;
    assign w_beat_fire = in_valid & r_in_ready;
    assign w_cnt_nxt   = r_cnt + LEN_ONE;

    assign cfg_ready = r_cfg_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;

`ifdef MAC_SAT_EN
    logic [NUM_LANES-1:0] r_sat;
    logic [NUM_LANES-1:0] w_sat_hit;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [W-1:0]  w_a;
        logic [W-1:0]  w_b;
        logic [PW-1:0] w_ea;
        logic [PW-1:0] w_eb;
        logic [AW-1:0] w_pext;

        // Extending both operands to PW bits makes the low PW bits of the
        // product correct for both signed and unsigned interpretations.
        assign w_a  = in_a[g*W +: W];
        assign w_b  = in_b[g*W +: W];
        assign w_ea = r_signed ? {{W{w_a[W-1]}}, w_a} : {{W{1'b0}}, w_a};
        assign w_eb = r_signed ? {{W{w_b[W-1]}}, w_b} : {{W{1'b0}}, w_b};
        assign w_prod[g] = w_ea * w_eb;

        assign w_pext = r_signed ? {{(AW-PW){r_prod[g][PW-1]}}, r_prod[g]}
                                 : {{(AW-PW){1'b0}}, r_prod[g]};

`ifdef MAC_SAT_EN
        logic [AW:0]   w_sum;
        logic          w_ovf;
        logic [AW-1:0] w_clamp;

        // One guard bit exposes signed overflow (guard != msb) or unsigned carry-out.
        assign w_sum   = r_signed ? ({r_acc[g][AW-1], r_acc[g]} + {w_pext[AW-1], w_pext})
                                  : ({1'b0, r_acc[g]} + {1'b0, w_pext});
        assign w_ovf   = r_signed ? (w_sum[AW] != w_sum[AW-1]) : w_sum[AW];
        assign w_clamp = r_signed ? (w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})
                                  : {AW{1'b1}};
        assign w_acc_nxt[g] = w_ovf ? w_clamp : w_sum[AW-1:0];
        assign w_sat_hit[g] = w_ovf;
`else
        assign w_acc_nxt[g] = r_acc[g] + w_pext;
`endif
    end

    // Control FSM: transaction sequencing with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_fire) begin
                        r_signed    <= cfg_signed;
                        r_len       <= cfg_len;
                        r_cnt       <= '0;
                        r_cfg_ready <= 1'b0;
                        if (cfg_len != '0) begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_beat_fire) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final product is folded into the accumulator on this edge.
                    r_state     <= S_HOLD;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cfg_ready <= 1'b1;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: stage 1 registers products, stage 2 accumulates them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod_vld <= 1'b0;
            r_prod     <= '0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= w_beat_fire;
            if (w_beat_fire) begin
                r_prod <= w_prod;
            end
            if (w_cfg_fire) begin
                r_acc <= cfg_init;
            end else if (r_prod_vld) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

`ifdef MAC_SAT_EN
    // Sticky per-lane clamp flags, cleared by a new configuration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat <= '0;
        end else if (w_cfg_fire) begin
            r_sat <= '0;
        end else if (r_prod_vld) begin
            r_sat <= r_sat | w_sat_hit;
        end
    end

    assign sat_flag = r_sat;
`else
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_mac_stream_cluster.sv
// Self-checking bench for mac_stream_cluster: table of directed transactions,
// reset-abort sequence and random transactions checked through a result queue.
// Expected results come from constants or a behavioural integer model.
module tb_mac_stream_cluster;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 32;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_signed;
    logic [LW-1:0]     cfg_len;
    logic [N*AW-1:0]   cfg_init;
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    in_a;
    logic [N*W-1:0]    in_b;
    logic              out_valid;
    logic              out_ready;
    logic [N*AW-1:0]   out_data;
    logic [N-1:0]      sat_flag;

    int checks = 0;
    int errors = 0;

    logic [N*AW-1:0] exp_q[$];
    logic [N-1:0]    sat_q[$];
    logic [N*AW-1:0] mon_e;
    logic [N-1:0]    mon_s;

    typedef struct {
        logic            sgn;
        int              len;
        logic [N*AW-1:0] init;
        logic [N*W-1:0]  a;
        logic [N*W-1:0]  b;
        logic [N*AW-1:0] exp;
        logic [N-1:0]    sat;
        int              gap;
        int              hold;
    } vec_t;

    vec_t vecs[5];

    mac_stream_cluster #(
        .NUM_LANES    (N),
        .MAC_MIN_WIDTH(W),
        .MAC_ACC_WIDTH(AW),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_signed(cfg_signed),
        .cfg_len   (cfg_len),
        .cfg_init  (cfg_init),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Behavioural reference: integer arithmetic per lane, then wrap or clamp.
    function automatic void model(input logic sgn, input int len, input logic [N*AW-1:0] init,
                                  input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                  output logic [N*AW-1:0] res, output logic [N-1:0] sat);
        longint   acc;
        longint   p;
        longint   sum;
        logic [W-1:0]  ai;
        logic [W-1:0]  bi;
        logic [AW-1:0] t;
        res = '0;
        sat = '0;
        for (int i = 0; i < N; i++) begin
            ai  = a[i*W +: W];
            bi  = b[i*W +: W];
            t   = init[i*AW +: AW];
            acc = sgn ? longint'($signed(t)) : longint'(t);
            p   = sgn ? longint'($signed(ai)) * longint'($signed(bi)) : longint'(ai) * longint'(bi);
            for (int k = 0; k < len; k++) begin
                sum = acc + p;
`ifdef MAC_SAT_EN
                if (sgn) begin
                    if (sum > 64'sd2147483647) begin sum = 64'sd2147483647; sat[i] = 1'b1; end
                    else if (sum < -64'sd2147483648) begin sum = -64'sd2147483648; sat[i] = 1'b1; end
                end else if (sum > 64'sd4294967295) begin
                    sum = 64'sd4294967295;
                    sat[i] = 1'b1;
                end
`endif
                t   = sum[AW-1:0];
                acc = sgn ? longint'($signed(t)) : longint'(t);
            end
            res[i*AW +: AW] = acc[AW-1:0];
        end
    endfunction

    // Result scoreboard: every accepted result is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected no result", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = sat_q.pop_front();
                chk("result_data", out_data, mon_e);
                chk("result_sat", 128'(sat_flag), 128'(mon_s));
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int cyc;
        exp_q.push_back(v.exp);
        sat_q.push_back(v.sat);
        @(posedge clk); #1;
        cfg_valid  = 1'b1;
        cfg_signed = v.sgn;
        cfg_len    = LW'(v.len);
        cfg_init   = v.init;
        cyc = 0;
        @(negedge clk);
        while (!cfg_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("cfg_ready_wait", 128'(cfg_ready), 128'(1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (v.len == 0) begin
            @(negedge clk);
            chk("len0_out_valid", 128'(out_valid), 128'(1));
        end else begin
            for (int k = 0; k < v.len; k++) begin
                if (v.gap != 0 && (k == 1 || k == 2)) begin
                    // Gap cycle; a stray config offer here must be ignored.
                    in_valid  = 1'b0;
                    cfg_valid = 1'b1;
                    cfg_init  = '1;
                    @(posedge clk); #1;
                    cfg_valid = 1'b0;
                end
                in_valid = 1'b1;
                in_a     = v.a;
                in_b     = v.b;
                cyc = 0;
                @(negedge clk);
                while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
                if (!in_ready) chk("in_ready_wait", 128'(in_ready), 128'(1));
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("drain_out_valid", 128'(out_valid), 128'(0));
            chk("drain_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
            chk("latency_out_valid", 128'(out_valid), 128'(1));
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_data", out_data, v.exp);
            chk("hold_ctrl", {125'b0, out_valid, cfg_ready, in_ready}, {125'b0, 3'b100});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!out_valid) chk("out_valid_wait", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_accept_idle", {126'b0, out_valid, cfg_ready}, {126'b0, 2'b01});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   ov_cnt;

        // sgn, len, init, a, b, expected data, expected sat, gap, hold
        vecs[0] = '{1'b0, 1, '0, {4{8'hFF}}, {4{8'hFF}}, {4{32'd65025}}, 4'h0, 0, 0};
        vecs[1] = '{1'b1, 3, {4{32'd10}}, {4{8'h80}}, {4{8'h7F}}, {4{32'hFFFF418A}}, 4'h0, 0, 1};
        vecs[2] = '{1'b0, 4, '0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
                    {32'd128, 32'd84, 32'd48, 32'd20}, 4'h0, 1, 5};
        vecs[3] = '{1'b0, 0, {32'd4, 32'd3, 32'd2, 32'd1}, '0, '0,
                    {32'd4, 32'd3, 32'd2, 32'd1}, 4'h0, 0, 2};
`ifdef MAC_SAT_EN
        vecs[4] = '{1'b0, 1, {4{32'hFFFFFFF0}}, {4{8'd16}}, {4{8'd16}}, {4{32'hFFFFFFFF}}, 4'hF, 0, 0};
`else
        vecs[4] = '{1'b0, 1, {4{32'hFFFFFFF0}}, {4{8'd16}}, {4{8'd16}}, {4{32'h000000F0}}, 4'h0, 0, 0};
`endif

        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_signed = 1'b0;
        cfg_len    = '0;
        cfg_init   = '0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cfg_ready", 128'(cfg_ready), 128'(1));
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_data", out_data, 128'(0));
        chk("reset_sat_flag", 128'(sat_flag), 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
        end

        // Reset after two of four beats: partial work discarded, no result.
        @(posedge clk); #1;
        cfg_valid  = 1'b1;
        cfg_signed = 1'b0;
        cfg_len    = 8'd4;
        cfg_init   = {4{32'd7}};
        @(negedge clk);
        chk("abort_cfg_ready", 128'(cfg_ready), 128'(1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b1;
        in_a      = {4{8'd9}};
        in_b      = {4{8'd9}};
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_data", out_data, 128'(0));
        chk("abort_ctrl", {126'b0, cfg_ready, in_ready}, {126'b0, 2'b10});
        chk("abort_sat_flag", 128'(sat_flag), 128'(0));
        ov_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_result", 128'(ov_cnt), 128'(0));
        run_txn(vecs[0]);

        // Random transactions against the behavioural model.
        for (int r = 0; r < 8; r++) begin
            rv.sgn  = 1'($urandom_range(0, 1));
            rv.len  = $urandom_range(1, 6);
            rv.init = {$urandom, $urandom, $urandom, $urandom};
            rv.a    = $urandom;
            rv.b    = $urandom;
            rv.gap  = r % 2;
            rv.hold = r % 3;
            model(rv.sgn, rv.len, rv.init, rv.a, rv.b, rv.exp, rv.sat);
            run_txn(rv);
        end

        // Near-overflow signed case exercising the wrap / clamp path.
        rv.sgn  = 1'b1;
        rv.len  = 5;
        rv.init = {4{32'h7FFF0000}};
        rv.a    = {4{8'h7F}};
        rv.b    = {4{8'h7F}};
        rv.gap  = 0;
        rv.hold = 0;
        model(rv.sgn, rv.len, rv.init, rv.a, rv.b, rv.exp, rv.sat);
        run_txn(rv);

        repeat (3) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
